snax_alu_pe_acc: RTL and testbench
==================================

# snax_alu_pe_acc

Parametrised successor to the SNAX ALU processing element. It adds a registered, back-pressure-safe output stage, signed/unsigned elementwise operations, and two reduction modes (MAC, add-accumulate) that fold a programmable number of operand pairs into one result. It sits in the SNAX ALU accelerator datapath, one instance per lane, between the streamer read ports (A, B) and the streamer write port (C).

## Interface
- DataWidth, default 64: operand width; result is 2*DataWidth.
- CntWidth, default 16: width of the reduction-length counter.
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- a_i, in, DataWidth: operand A.
- a_valid_i, in, 1: A valid.
- a_ready_o, out, 1: A ready.
- b_i, in, DataWidth: operand B.
- b_valid_i, in, 1: B valid.
- b_ready_o, out, 1: B ready.
- c_o, out, 2*DataWidth: registered result.
- c_valid_o, out, 1: result valid.
- c_ready_i, in, 1: result consumed.
- alu_config_i, in, 3: op select: 0 ADD, 1 SUB, 2 MUL, 3 XOR, 4 SMUL (signed), 5 MAC, 6 ACCADD, 7 reserved.
- acc_len_i, in, CntWidth: operand pairs per reduction; 0 is treated as 1.
- busy_o, out, 1: reduction in progress (counter non-zero).

## Operation
- Input fire = a_valid_i & b_valid_i & a_ready_o & b_ready_o. A and B are consumed only jointly.
- a_ready_o = b_ready_o = !c_valid_o | c_ready_i. Ready never depends on the valid inputs.
- Arithmetic is unsigned, zero-extended to 2*DataWidth, and taken mod 2^(2*DataWidth).
  - ADD keeps the carry.
  - SUB wraps, e.g. 1-2 = all ones.
  - MUL is the full product.
  - XOR upper half is 0.
  - SMUL sign-extends both operands and gives the full signed product.
- Elementwise ops (0-4, 7) load the result into the output register on each fire. Op 7 produces 0.
- Reduction ops (5, 6):
  - Internal acc register (2*DataWidth) and cnt register (CntWidth).
  - On a fire with cnt < len-1: acc += a*b (MAC) or acc += a+b (ACCADD); cnt++.
  - On a fire with cnt == len-1: output register gets acc + term; acc and cnt clear to 0.
- alu_config_i and acc_len_i are latched into op_q/len_q on the first fire of a batch (cnt == 0), and on every fire of an elementwise op. Changes while busy_o = 1 are ignored until the batch completes.
- The datapath uses the latched op while busy; otherwise it uses live alu_config_i.

## Timing
- Reset values: c_o = 0, c_valid_o = 0, busy_o = 0. acc, cnt, op_q, len_q = 0. a_ready_o/b_ready_o = 1 after reset.
- Elementwise latency: 1 cycle, fire in cycle n gives c_valid_o in n+1. Throughput is 1/cycle while c_ready_i = 1.
- Reduction latency: result is valid 1 cycle after the len-th fire. A new batch can start on the very next cycle.
- Output register full and c_ready_i = 0: ready low, no fire. c_o and c_valid_o are held stable until the handshake.
- Drain and fire in the same cycle: the old result leaves and the new one loads, so c_valid_o stays 1.
- Reduction stalls mid-batch (inputs not valid, or output back-pressure): acc and cnt hold.
- Reset asserted mid-batch or with an output pending: everything clears asynchronously and the partial result is discarded.
- cnt never exceeds len_q-1. With len = 2^CntWidth-1 the counter does not wrap.

## Structure
- Package snax_alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e (the op encodings above).
  - Helper function is_reduce(op).
- Sub-module snax_alu_op_unit is purely combinational: op, a, b, acc in; 2*DataWidth term and next-acc out. Instantiated once.
- Top level holds the handshake, the output register, acc, cnt, and the config latches.

## Test plan
- Reset, then DataWidth = 16, ADD 0xFFFF+0x0001 with c_ready_i = 1: one cycle later c_o = 0x0001_0000, c_valid_o = 1, ready stays 1.
- SUB 1-2 then SMUL 0xFFFF*0x0002: c_o = 0xFFFF_FFFF, then c_o = 0xFFFF_FFFE, one per cycle back-to-back.
- MAC, len = 4, pairs (1,2),(3,4),(5,6),(7,8): busy_o goes high after the first fire; a single output of 100 follows the 4th fire, and busy_o returns to 0.
- Back-pressure: c_ready_i = 0 with a result pending: ready is 0, inputs held valid are not consumed. Releasing c_ready_i for 1 cycle drains and loads the next result in the same cycle.
- ACCADD, len = 3: change alu_config_i to XOR after the first fire. The result is still (a0+b0)+(a1+b1)+(a2+b2), and the next batch uses XOR.
- Assert rst_ni mid-batch after 2 of 4 MAC fires: all outputs and busy_o go to 0. A fresh len = 1 MAC of (3,5) then yields 15.

Source files
------------

// File: rtl/snax_alu_pkg.sv
// Shared types and helpers for the SNAX ALU processing element with reductions.
package snax_alu_pkg;

  typedef enum logic [2:0] {
    OpAdd    = 3'd0,
    OpSub    = 3'd1,
    OpMul    = 3'd2,
    OpXor    = 3'd3,
    OpSmul   = 3'd4,
    OpMac    = 3'd5,
    OpAccAdd = 3'd6,
    OpRsvd   = 3'd7
  } alu_op_e;

  function automatic logic is_reduce(alu_op_e op);
    return (op == OpMac) || (op == OpAccAdd);
  endfunction

endpackage

// File: rtl/snax_alu_op_unit.sv
// Combinational ALU: per-pair term for the selected op and the accumulator plus that term.
module snax_alu_op_unit import snax_alu_pkg::*; #(
  parameter int unsigned DataWidth = 64
) (
  input  alu_op_e                  op_i,
  input  logic [DataWidth-1:0]     a_i,
  input  logic [DataWidth-1:0]     b_i,
  input  logic [2*DataWidth-1:0]   acc_i,
  output logic [2*DataWidth-1:0]   term_o,
  output logic [2*DataWidth-1:0]   acc_next_o
);

  localparam int unsigned ResWidth = 2 * DataWidth;

  logic [ResWidth-1:0] a_zext, b_zext, a_sext, b_sext;

  assign a_zext = {{DataWidth{1'b0}}, a_i};
  assign b_zext = {{DataWidth{1'b0}}, b_i};
  // Truncated product of sign-extended operands equals the full signed product.
  assign a_sext = {{DataWidth{a_i[DataWidth-1]}}, a_i};
  assign b_sext = {{DataWidth{b_i[DataWidth-1]}}, b_i};

  always_comb begin
    term_o = '0;
    case (op_i)
      OpAdd, OpAccAdd: term_o = a_zext + b_zext;
      OpSub:           term_o = a_zext - b_zext;
      OpMul, OpMac:    term_o = a_zext * b_zext;
      OpXor:           term_o = a_zext ^ b_zext;
      OpSmul:          term_o = a_sext * b_sext;
      default:         term_o = '0;
    endcase
  end

  assign acc_next_o = acc_i + term_o;

endmodule

// File: rtl/snax_alu_pe_acc.sv
// SNAX ALU lane: joint A/B handshake, elementwise ops and MAC/add reductions into a
// back-pressure-safe registered output.
module snax_alu_pe_acc import snax_alu_pkg::*; #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DataWidth-1:0]   a_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [DataWidth-1:0]   b_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  output logic [2*DataWidth-1:0] c_o,
  output logic                   c_valid_o,
  input  logic                   c_ready_i,
  input  logic [2:0]             alu_config_i,
  input  logic [CntWidth-1:0]    acc_len_i,
  output logic                   busy_o
);

  localparam int unsigned ResWidth = 2 * DataWidth;

  logic [ResWidth-1:0] c_q, c_d, acc_q, acc_d;
  logic                c_valid_q, c_valid_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, len_q, len_d;
  alu_op_e             op_q, op_d;

  logic                busy, in_ready, fire, reduce, last;
  alu_op_e             cfg_op, op_cur;
  logic [CntWidth-1:0] len_cur, len_last;
  logic [ResWidth-1:0] term, acc_next;

  assign busy     = (cnt_q != '0);
  assign in_ready = !c_valid_q || c_ready_i;
  assign fire     = a_valid_i && b_valid_i && in_ready;

  // Mid-batch the latched config wins so live config changes cannot corrupt the batch.
  assign cfg_op   = alu_op_e'(alu_config_i);
  assign op_cur   = busy ? op_q : cfg_op;
  assign len_cur  = busy ? len_q : acc_len_i;
  assign len_last = (len_cur == '0) ? '0 : len_cur - CntWidth'(1);
  assign reduce   = is_reduce(op_cur);
  assign last     = (cnt_q == len_last);

  snax_alu_op_unit #(
    .DataWidth (DataWidth)
  ) u_op_unit (
    .op_i       (op_cur),
    .a_i        (a_i),
    .b_i        (b_i),
    .acc_i      (acc_q),
    .term_o     (term),
    .acc_next_o (acc_next)
  );

  always_comb begin
    c_d       = c_q;
    c_valid_d = c_valid_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    len_d     = len_q;
    if (c_ready_i) c_valid_d = 1'b0;
    if (fire) begin
      if (!busy) begin
        op_d  = cfg_op;
        len_d = acc_len_i;
      end
      if (!reduce) begin
        c_d       = term;
        c_valid_d = 1'b1;
      end else if (last) begin
        c_d       = acc_next;
        c_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q       <= '0;
      c_valid_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= OpAdd;
      len_q     <= '0;
    end else begin
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      len_q     <= len_d;
    end
  end

  assign a_ready_o = in_ready;
  assign b_ready_o = in_ready;
  assign c_o       = c_q;
  assign c_valid_o = c_valid_q;
  assign busy_o    = busy;

endmodule

// File: tb/tb_snax_alu_pe_acc.sv
// Scoreboard bench for snax_alu_pe_acc at DataWidth = 16.
module tb_snax_alu_pe_acc;
  import snax_alu_pkg::*;

  localparam int unsigned Dw = 16;
  localparam int unsigned Cw = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [Dw-1:0]   a = '0, b = '0;
  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic            a_ready, b_ready;
  logic [2*Dw-1:0] c;
  logic            c_valid;
  logic            c_ready = 1'b1;
  logic [2:0]      alu_config = 3'd0;
  logic [Cw-1:0]   acc_len = '0;
  logic            busy;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [2*Dw-1:0] exp_q[$];

  always #5 clk = ~clk;

  snax_alu_pe_acc #(
    .DataWidth (Dw),
    .CntWidth  (Cw)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .a_i          (a),
    .a_valid_i    (a_valid),
    .a_ready_o    (a_ready),
    .b_i          (b),
    .b_valid_i    (b_valid),
    .b_ready_o    (b_ready),
    .c_o          (c),
    .c_valid_o    (c_valid),
    .c_ready_i    (c_ready),
    .alu_config_i (alu_config),
    .acc_len_i    (acc_len),
    .busy_o       (busy)
  );

  // Monitor: pops an expectation for every output handshake, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (rst_n && c_valid && c_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got c=%h with no expected result queued", c);
      end else begin
        logic [2*Dw-1:0] e;
        e = exp_q.pop_front();
        if (c !== e) begin
          bad++;
          $display("FAIL out_value: got c=%h expected %h", c, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [2*Dw-1:0] got, input logic [2*Dw-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the fire with valids dropped.
  task automatic send(input logic [2:0] op, input logic [Cw-1:0] len, input logic [Dw-1:0] av,
                      input logic [Dw-1:0] bv, input bit push, input logic [2*Dw-1:0] e);
    int n;
    alu_config = op;
    acc_len    = len;
    a = av;
    b = bv;
    a_valid = 1'b1;
    b_valid = 1'b1;
    if (push) exp_q.push_back(e);
    n = 0;
    while (!(a_ready && b_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready=%b expected 1 within 50 cycles", a_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_c", c, '0);
    check("reset_c_valid", {31'd0, c_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {30'd0, a_ready, b_ready}, 32'd3);
    rst_n = 1'b1;
    @(negedge clk);

    // Elementwise ops, back-to-back
    send(OpAdd, 0, 16'hFFFF, 16'h0001, 1, 32'h0001_0000);
    check("add_valid", {31'd0, c_valid}, 32'd1);
    check("add_ready", {31'd0, a_ready}, 32'd1);
    send(OpSub, 0, 16'h0001, 16'h0002, 1, 32'hFFFF_FFFF);
    send(OpSmul, 0, 16'hFFFF, 16'h0002, 1, 32'hFFFF_FFFE);
    send(OpMul, 0, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001);
    send(OpXor, 0, 16'hF0F0, 16'h0FF0, 1, 32'h0000_FF00);
    send(OpRsvd, 0, 16'h1234, 16'h5678, 1, 32'h0000_0000);

    // MAC len 4: 1*2 + 3*4 + 5*6 + 7*8 = 100
    send(OpMac, 4, 16'd1, 16'd2, 0, '0);
    check("mac_busy_first", {31'd0, busy}, 32'd1);
    check("mac_no_early_out", {31'd0, c_valid}, 32'd0);
    send(OpMac, 4, 16'd3, 16'd4, 0, '0);
    send(OpMac, 4, 16'd5, 16'd6, 0, '0);
    send(OpMac, 4, 16'd7, 16'd8, 1, 32'd100);
    check("mac_busy_done", {31'd0, busy}, 32'd0);
    check("mac_valid", {31'd0, c_valid}, 32'd1);

    // Length 0 behaves as length 1
    send(OpMac, 0, 16'd4, 16'd4, 1, 32'd16);

    // Back-pressure: pending result blocks inputs, one drain cycle loads the next
    @(negedge clk);
    c_ready = 1'b0;
    send(OpAdd, 0, 16'd5, 16'd6, 1, 32'd11);
    alu_config = OpAdd;
    a = 16'd7;
    b = 16'd8;
    a_valid = 1'b1;
    b_valid = 1'b1;
    exp_q.push_back(32'd15);
    repeat (3) @(negedge clk);
    check("bp_ready_low", {30'd0, a_ready, b_ready}, 32'd0);
    check("bp_c_held", c, 32'd11);
    check("bp_valid_held", {31'd0, c_valid}, 32'd1);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("bp_reload_valid", {31'd0, c_valid}, 32'd1);
    check("bp_reload_c", c, 32'd15);
    @(negedge clk);
    c_ready = 1'b1;
    @(negedge clk);

    // ACCADD len 3 ignores mid-batch config change: 30 + 3 + 7 = 40
    send(OpAccAdd, 3, 16'd10, 16'd20, 0, '0);
    send(OpXor, 1, 16'd1, 16'd2, 0, '0);
    check("accadd_busy", {31'd0, busy}, 32'd1);
    send(OpXor, 1, 16'd3, 16'd4, 1, 32'd40);
    check("accadd_busy_done", {31'd0, busy}, 32'd0);
    send(OpXor, 1, 16'h00F0, 16'h0FF0, 1, 32'h0000_0F00);
    @(negedge clk);

    // Reset mid-batch discards the partial sum
    send(OpMac, 4, 16'd2, 16'd3, 0, '0);
    send(OpMac, 4, 16'd4, 16'd5, 0, '0);
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_c", c, '0);
    check("rst_c_valid", {31'd0, c_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(OpMac, 1, 16'd3, 16'd5, 1, 32'd15);
    repeat (3) @(negedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
